// File: rtl/encoder_axis_ctrl.sv
// encoder_axis_ctrl: one quadrature-encoder axis.
// Synchronises and filters the A/B/index pins, decodes x4 steps, and owns the
// axis coordinate through an IDLE / HOMING / TRACK / FAULT state machine.
// Optional build macro COORD_WRAP_EN: coordinate wraps modulo COORD_MAX+1 and a
// one-cycle 'wrap' output pulses on every wrap; without it the coordinate
// saturates at 0 and COORD_MAX and the 'wrap' port does not exist.
module encoder_axis_ctrl #(
   parameter int WIDTH      = 10,
   parameter int COORD_MAX  = 1023,
   parameter int FILTER_LEN = 2,
   parameter int HOME_VALUE = 0
) (
   input  logic             clock,
   input  logic             a_reset,
   input  logic             encoder_a,
   input  logic             encoder_b,
   input  logic             index,
   input  logic             cmd_home,
   input  logic             cmd_load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             cmd_clear,
   output logic [WIDTH-1:0] coordinate,
   output logic [1:0]       state,
   output logic             step_valid,
   output logic             direction,
   output logic             homed,
   output logic             fault
`ifdef COORD_WRAP_EN
   ,
   output logic             wrap
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOMING = 2'd1,
      ST_TRACK  = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_UP      = 2'd1,
      EV_DOWN    = 2'd2,
      EV_ILLEGAL = 2'd3
   } step_t;

   localparam logic [WIDTH:0]   CMAX_EXT  = (WIDTH+1)'(COORD_MAX);
   localparam logic [WIDTH-1:0] CMAX      = WIDTH'(COORD_MAX);
   localparam logic [WIDTH-1:0] HOME      = WIDTH'(HOME_VALUE);
   localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);

   // Gray-code step classification of a {A,B} transition; up is 00->10->11->01->00.
   function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
      step_t ev;
      case ({prev, cur})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: ev = EV_UP;
         4'b1000, 4'b1110, 4'b0111, 4'b0001: ev = EV_DOWN;
         4'b0011, 4'b1100, 4'b1001, 4'b0110: ev = EV_ILLEGAL;
         default:                            ev = EV_NONE;
      endcase
      return ev;
   endfunction

   logic [2:0]       pins_s;
   logic [2:0]       sync1_r;
   logic [2:0]       sync2_r;
   logic [2:0]       filt_s;
   logic [1:0]       ab_s;
   logic [1:0]       prev_ab_r;
   logic             idx_prev_r;
   logic             idx_rise_s;
   step_t            event_s;
   logic             step_up_s;
   logic             step_dn_s;
   logic             illegal_s;

   state_t           state_r;
   state_t           state_n;
   logic [WIDTH-1:0] coord_r;
   logic [WIDTH-1:0] coord_n;
   logic             homed_r;
   logic             homed_n;
   logic             fault_r;
   logic             step_valid_r;
   logic             direction_r;

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] inc_s;
   logic [WIDTH-1:0] dec_s;
   logic [WIDTH-1:0] load_clamp_s;
`ifdef COORD_WRAP_EN
   logic             inc_wrap_s;
   logic             dec_wrap_s;
   logic             wrap_n;
   logic             wrap_r;
`endif

   // bit 2 = index, bit 1 = A, bit 0 = B
   assign pins_s = {index, encoder_a, encoder_b};

   // Two-flop synchroniser for the three asynchronous pins.
   always_ff @(posedge clock or posedge a_reset) begin
      if (a_reset) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
      end else begin
         sync1_r <= pins_s;
         sync2_r <= sync1_r;
      end
   end

   generate
      for (genvar g = 0; g < 3; g++) begin : g_filt
         logic [3:0] cnt_r;
         logic       level_r;

         // Accept a new level only after FILTER_LEN consecutive disagreeing samples.
         always_ff @(posedge clock or posedge a_reset) begin
            if (a_reset) begin
               cnt_r   <= 4'd0;
               level_r <= 1'b0;
            end else if (sync2_r[g] == level_r) begin
               cnt_r   <= 4'd0;
            end else if (cnt_r == FILT_LAST) begin
               cnt_r   <= 4'd0;
               level_r <= sync2_r[g];
            end else begin
               cnt_r   <= cnt_r + 4'd1;
            end
         end

         assign filt_s[g] = level_r;
      end
   endgenerate

   assign ab_s       = filt_s[1:0];
   assign event_s    = decode_step(prev_ab_r, ab_s);
   assign step_up_s  = (event_s == EV_UP);
   assign step_dn_s  = (event_s == EV_DOWN);
   assign illegal_s  = (event_s == EV_ILLEGAL);
   assign idx_rise_s = filt_s[2] & ~idx_prev_r;

   // Neighbouring coordinates (one extra bit to see over/underflow) and load clamp.
   always_comb begin
      sum_s  = {1'b0, coord_r} + {{WIDTH{1'b0}}, 1'b1};
      diff_s = {1'b0, coord_r} - {{WIDTH{1'b0}}, 1'b1};
`ifdef COORD_WRAP_EN
      inc_wrap_s = 1'b0;
      dec_wrap_s = 1'b0;
      if (sum_s > CMAX_EXT) begin
         inc_s      = {WIDTH{1'b0}};
         inc_wrap_s = 1'b1;
      end else begin
         inc_s      = sum_s[WIDTH-1:0];
      end
      if (diff_s[WIDTH]) begin
         dec_s      = CMAX;
         dec_wrap_s = 1'b1;
      end else begin
         dec_s      = diff_s[WIDTH-1:0];
      end
`else
      if (sum_s > CMAX_EXT) begin
         inc_s = CMAX;
      end else begin
         inc_s = sum_s[WIDTH-1:0];
      end
      if (diff_s[WIDTH]) begin
         dec_s = {WIDTH{1'b0}};
      end else begin
         dec_s = diff_s[WIDTH-1:0];
      end
`endif
      if ({1'b0, load_value} > CMAX_EXT) begin
         load_clamp_s = CMAX;
      end else begin
         load_clamp_s = load_value;
      end
   end

   // Next state and coordinate; priority illegal > clear > home > load > index > step.
   always_comb begin
      state_n = state_r;
      coord_n = coord_r;
      homed_n = homed_r;
`ifdef COORD_WRAP_EN
      wrap_n  = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (cmd_home) begin
               state_n = ST_HOMING;
               homed_n = 1'b0;
            end else if (cmd_load) begin
               state_n = ST_TRACK;
               coord_n = load_clamp_s;
               homed_n = 1'b1;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_HOMING: begin
            if (illegal_s) begin
               state_n = ST_FAULT;
            end else if (cmd_home) begin
               homed_n = 1'b0;
            end else if (cmd_load) begin
               state_n = ST_TRACK;
               coord_n = load_clamp_s;
               homed_n = 1'b1;
            end else if (idx_rise_s) begin
               state_n = ST_TRACK;
               coord_n = HOME;
               homed_n = 1'b1;
            end else begin
               state_n = ST_HOMING;
            end
         end
         ST_TRACK: begin
            if (illegal_s) begin
               state_n = ST_FAULT;
            end else if (cmd_home) begin
               state_n = ST_HOMING;
               homed_n = 1'b0;
            end else if (cmd_load) begin
               coord_n = load_clamp_s;
               homed_n = 1'b1;
            end else if (step_up_s) begin
               coord_n = inc_s;
`ifdef COORD_WRAP_EN
               wrap_n  = inc_wrap_s;
`endif
            end else if (step_dn_s) begin
               coord_n = dec_s;
`ifdef COORD_WRAP_EN
               wrap_n  = dec_wrap_s;
`endif
            end else begin
               state_n = ST_TRACK;
            end
         end
         ST_FAULT: begin
            if (cmd_clear) begin
               state_n = ST_IDLE;
               homed_n = 1'b0;
            end else begin
               state_n = ST_FAULT;
            end
         end
         default: begin
            state_n = ST_IDLE;
            homed_n = 1'b0;
         end
      endcase
   end

   // State, coordinate and pulse outputs; previous AB / index always track the filters.
   always_ff @(posedge clock or posedge a_reset) begin
      if (a_reset) begin
         state_r      <= ST_IDLE;
         coord_r      <= {WIDTH{1'b0}};
         homed_r      <= 1'b0;
         fault_r      <= 1'b0;
         step_valid_r <= 1'b0;
         direction_r  <= 1'b0;
         prev_ab_r    <= 2'b00;
         idx_prev_r   <= 1'b0;
`ifdef COORD_WRAP_EN
         wrap_r       <= 1'b0;
`endif
      end else begin
         state_r      <= state_n;
         coord_r      <= coord_n;
         homed_r      <= homed_n;
         fault_r      <= (state_n == ST_FAULT);
         step_valid_r <= step_up_s | step_dn_s;
         if (step_up_s) begin
            direction_r <= 1'b1;
         end else if (step_dn_s) begin
            direction_r <= 1'b0;
         end else begin
            direction_r <= direction_r;
         end
         prev_ab_r    <= ab_s;
         idx_prev_r   <= filt_s[2];
`ifdef COORD_WRAP_EN
         wrap_r       <= wrap_n;
`endif
      end
   end

   assign coordinate = coord_r;
   assign state      = state_r;
   assign step_valid = step_valid_r;
   assign direction  = direction_r;
   assign homed      = homed_r;
   assign fault      = fault_r;
`ifdef COORD_WRAP_EN
   assign wrap       = wrap_r;
`endif

endmodule
